uart_tx_arb: RTL and testbench

- Shares the single UART transmitter byte interface (tx_data / new_tx_data / tx_busy) between NREQ byte-stream requesters, e.g. the parser response path and the miner result reporter.
- Arbitration is round-robin at packet granularity: once a requester is granted, it keeps the transmitter until it sends a byte flagged last, or until it stalls too long.
- Sits between the requesters and uart_top inside the uart2core hierarchy.

---
 rtl/uart_tx_arb.sv | 179 +++++++++++++++++
 tb/tb_uart_tx_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin, packet-granular arbiter that shares one UART transmitter byte
// interface (tx_data / new_tx_data / tx_busy) between NREQ byte-stream requesters.
//
// Requester handshake: a requester holds req_valid[i] high with req_data/req_last
// stable until it sees a one-cycle req_ready[i] pulse. That pulse means the byte
// was consumed. The pulse coincides with new_tx_data, which loads the byte into
// the transmitter.
module uart_tx_arb #(
    parameter int NREQ         = 2,
    parameter int BUSY_WAIT    = 4,
    parameter int LOCK_TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic [7:0]        tx_data,
    output logic              new_tx_data,
    input  logic              tx_busy,
    output logic              lock_abort,
    output logic              arb_busy
);

    localparam int              IW           = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0]      BW_LAST      = 3'(BUSY_WAIT - 1);
    localparam logic [15:0]     LOCK_LAST    = 16'(LOCK_TIMEOUT - 1);
    localparam logic [IW-1:0]   LAST_IDX_RST = IW'(NREQ - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND      = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        HOLD      = 3'd4
    } state_t;

    state_t          state_q;
    logic [NREQ-1:0] grant_q;
    logic [IW-1:0]   gidx_q;
    logic [IW-1:0]   last_grant_q;
    logic            last_flag_q;
    logic [2:0]      wait_cnt_q;
    logic [15:0]     lock_cnt_q;
    logic [NREQ-1:0] req_ready_q;
    logic [7:0]      tx_data_q;
    logic            new_tx_data_q;
    logic            lock_abort_q;

    logic            hi_found;
    logic [IW-1:0]   hi_idx;
    logic            lo_found;
    logic [IW-1:0]   lo_idx;
    logic            sel_found;
    logic [IW-1:0]   sel_idx;
    logic [NREQ-1:0] sel_onehot;

    logic            cur_valid;
    logic            cur_last;
    logic [7:0]      cur_data;

    // Round-robin pick: prefer the lowest valid index above last_grant. If there
    // is none, wrap to the lowest valid index overall.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_found = 1'b0;
        lo_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = IW'(i);
                if (IW'(i) > last_grant_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(i);
                end
            end
        end
        sel_found = lo_found;
        sel_idx   = hi_found ? hi_idx : lo_idx;
    end

    assign sel_onehot = NREQ'(1) << sel_idx;

    assign cur_valid = req_valid[gidx_q];
    assign cur_last  = req_last[gidx_q];
    assign cur_data  = req_data[{gidx_q, 3'b000} +: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            grant_q       <= '0;
            gidx_q        <= '0;
            last_grant_q  <= LAST_IDX_RST;
            last_flag_q   <= 1'b0;
            wait_cnt_q    <= '0;
            lock_cnt_q    <= '0;
            req_ready_q   <= '0;
            tx_data_q     <= 8'h00;
            new_tx_data_q <= 1'b0;
            lock_abort_q  <= 1'b0;
        end else begin
            new_tx_data_q <= 1'b0;
            req_ready_q   <= '0;
            lock_abort_q  <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (sel_found) begin
                        grant_q <= sel_onehot;
                        gidx_q  <= sel_idx;
                        state_q <= SEND;
                    end
                end

                SEND: begin
                    tx_data_q     <= cur_data;
                    new_tx_data_q <= 1'b1;
                    req_ready_q   <= grant_q;
                    last_flag_q   <= cur_last;
                    wait_cnt_q    <= '0;
                    state_q       <= WAIT_BUSY;
                end

                // The counter fallback handles transmitters that never raise busy.
                WAIT_BUSY: begin
                    if (tx_busy || (wait_cnt_q == BW_LAST)) begin
                        state_q <= WAIT_DONE;
                    end else if (wait_cnt_q != 3'b111) begin
                        wait_cnt_q <= wait_cnt_q + 3'd1;
                    end
                end

                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_flag_q) begin
                            grant_q      <= '0;
                            last_grant_q <= gidx_q;
                            state_q      <= IDLE;
                        end else if (cur_valid) begin
                            state_q <= SEND;
                        end else begin
                            lock_cnt_q <= '0;
                            state_q    <= HOLD;
                        end
                    end
                end

                // Other requesters are ignored here; only the owner or the timeout can end the hold.
                HOLD: begin
                    if (cur_valid) begin
                        state_q <= SEND;
                    end else if (lock_cnt_q == LOCK_LAST) begin
                        lock_abort_q <= 1'b1;
                        grant_q      <= '0;
                        last_grant_q <= gidx_q;
                        state_q      <= IDLE;
                    end else if (lock_cnt_q != 16'hFFFF) begin
                        lock_cnt_q <= lock_cnt_q + 16'd1;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant       = grant_q;
    assign req_ready   = req_ready_q;
    assign tx_data     = tx_data_q;
    assign new_tx_data = new_tx_data_q;
    assign lock_abort  = lock_abort_q;
    assign arb_busy    = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: a simple transmitter model plus a scoreboard of expected
// {req_ready, tx_data} pairs checked on each new_tx_data strobe.
module tb_uart_tx_arb;

    localparam int NREQ         = 2;
    localparam int BUSY_WAIT    = 4;
    localparam int LOCK_TIMEOUT = 16;
    localparam int TX_LEN       = 6;
    localparam int TMO          = 300;
    localparam int EW           = NREQ + 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   grant;
    logic [7:0]        tx_data;
    logic              new_tx_data;
    logic              tx_busy = 1'b0;
    logic              lock_abort;
    logic              arb_busy;

    logic              rv [NREQ];
    logic [7:0]        rd [NREQ];
    logic              rl [NREQ];

    logic [EW-1:0]     exp_q[$];
    int                errors = 0;
    int                checks = 0;
    int                cyc = 0;
    int                tx_mode = 0;
    int                busy_cnt = 0;

    uart_tx_arb #(
        .NREQ(NREQ),
        .BUSY_WAIT(BUSY_WAIT),
        .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_data(req_data),
        .req_last(req_last),
        .req_ready(req_ready),
        .grant(grant),
        .tx_data(tx_data),
        .new_tx_data(new_tx_data),
        .tx_busy(tx_busy),
        .lock_abort(lock_abort),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]         = rv[i];
            req_data[8*i +: 8]   = rd[i];
            req_last[i]          = rl[i];
        end
    end

    // Transmitter model: busy for TX_LEN cycles after a load strobe. It ignores
    // rst, so a byte that is already loaded finishes on its own.
    always @(posedge clk) begin
        if (tx_mode == 0 && new_tx_data) begin
            tx_busy  <= 1'b1;
            busy_cnt <= TX_LEN;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) tx_busy <= 1'b0;
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [EW-1:0] exp_v;
        if (new_tx_data) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got ready=%b data=%h, required no transmission",
                         req_ready, tx_data);
            end else begin
                exp_v = exp_q.pop_front();
                if ({req_ready, tx_data} !== exp_v) begin
                    errors++;
                    $display("FAIL scoreboard: got ready=%b data=%h, required ready=%b data=%h",
                             req_ready, tx_data, exp_v[EW-1:8], exp_v[7:0]);
                end
            end
        end
    end

    function automatic logic [EW-1:0] pack(input int r, input logic [7:0] d);
        logic [NREQ-1:0] g;
        g    = '0;
        g[r] = 1'b1;
        return {g, d};
    endfunction

    // Driver: present n bytes from requester r, holding each until req_ready.
    task automatic send_bytes(input int r, input int n, input logic [7:0] base, input int last_every);
        for (int j = 0; j < n; j++) begin
            int t;
            rd[r] = base + 8'(j);
            rl[r] = (((j + 1) % last_every) == 0);
            rv[r] = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!req_ready[r] && t < TMO);
            checks++;
            if (!req_ready[r]) begin
                errors++;
                $display("FAIL send_r%0d_byte%0d: req_ready=0 after %0d cycles, required 1", r, j, t);
            end
        end
        rv[r] = 1'b0;
    endtask

    task automatic wait_busy_fall(output bit ok);
        int t;
        t = 0;
        while (!tx_busy && t < TMO) begin @(negedge clk); t++; end
        while (tx_busy && t < TMO) begin @(negedge clk); t++; end
        ok = (t < TMO);
    endtask

    task automatic wait_drain(output bit ok);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || arb_busy || tx_busy) && t < TMO) begin
            @(negedge clk);
            t++;
        end
        ok = (t < TMO);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) rv[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b, required 00", grant); end
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready: got %b, required 00", req_ready); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h, required 00", tx_data); end
        checks++; if (new_tx_data !== 1'b0) begin errors++; $display("FAIL reset_new_tx_data: got %b, required 0", new_tx_data); end
        checks++; if (lock_abort !== 1'b0) begin errors++; $display("FAIL reset_lock_abort: got %b, required 0", lock_abort); end
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL reset_arb_busy: got %b, required 0", arb_busy); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (arb_busy !== 1'b0 || grant !== 2'b00) begin
            errors++; $display("FAIL idle_after_reset: got arb_busy=%b grant=%b, required 0/00", arb_busy, grant);
        end
    endtask

    task automatic test_single();
        bit ok;
        rd[0] = 8'hA5; rl[0] = 1'b1; rv[0] = 1'b1;
        exp_q.push_back(pack(0, 8'hA5));
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant: got %b, required 01", grant); end
        @(negedge clk);
        checks++; if (new_tx_data !== 1'b1 || tx_data !== 8'hA5 || req_ready !== 2'b01) begin
            errors++; $display("FAIL single_send: got strobe=%b data=%h ready=%b, required 1/a5/01", new_tx_data, tx_data, req_ready);
        end
        rv[0] = 1'b0;
        wait_busy_fall(ok);
        checks++; if (!ok) begin errors++; $display("FAIL single_busy: busy cycle not seen, required rise and fall"); end
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_grant_hold: got %b, required 01", grant); end
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_release: got %b, required 00", grant); end
        @(negedge clk);
        checks++; if (arb_busy !== 1'b0) begin errors++; $display("FAIL single_idle: got arb_busy=%b, required 0", arb_busy); end
    endtask

    task automatic test_simultaneous();
        bit ok;
        do_reset();
        exp_q.push_back(pack(0, 8'h11));
        exp_q.push_back(pack(1, 8'h22));
        fork
            send_bytes(0, 1, 8'h11, 1);
            send_bytes(1, 1, 8'h22, 1);
        join
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL simul_drain: pending=%0d arb_busy=%b, required 0/0", exp_q.size(), arb_busy); end
    endtask

    task automatic test_alternate();
        bit ok;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(pack(0, 8'h30 + 8'(k)));
            exp_q.push_back(pack(1, 8'h40 + 8'(k)));
        end
        fork
            send_bytes(0, 3, 8'h30, 1);
            send_bytes(1, 3, 8'h40, 1);
        join
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL alternate_drain: pending=%0d arb_busy=%b, required 0/0", exp_q.size(), arb_busy); end
    endtask

    task automatic test_packet_lock();
        bit ok;
        @(negedge clk);
        for (int k = 0; k < 3; k++) exp_q.push_back(pack(0, 8'h50 + 8'(k)));
        exp_q.push_back(pack(1, 8'h60));
        fork
            send_bytes(0, 3, 8'h50, 3);
            send_bytes(1, 1, 8'h60, 1);
        join
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL lock_drain: pending=%0d arb_busy=%b, required 0/0", exp_q.size(), arb_busy); end
    endtask

    task automatic test_stall_timeout();
        bit ok;
        @(negedge clk);
        exp_q.push_back(pack(0, 8'h70));
        exp_q.push_back(pack(1, 8'h80));
        fork
            send_bytes(0, 1, 8'h70, 100);
            send_bytes(1, 1, 8'h80, 1);
            begin
                wait_busy_fall(ok);
                checks++; if (!ok) begin errors++; $display("FAIL stall_busy: busy cycle not seen, required rise and fall"); end
                repeat (LOCK_TIMEOUT) @(negedge clk);
                checks++; if (lock_abort !== 1'b0 || grant !== 2'b01) begin
                    errors++; $display("FAIL stall_early: got abort=%b grant=%b, required 0/01", lock_abort, grant);
                end
                @(negedge clk);
                checks++; if (lock_abort !== 1'b1 || grant !== 2'b00) begin
                    errors++; $display("FAIL stall_abort: got abort=%b grant=%b, required 1/00", lock_abort, grant);
                end
                @(negedge clk);
                checks++; if (lock_abort !== 1'b0 || grant !== 2'b10) begin
                    errors++; $display("FAIL stall_regrant: got abort=%b grant=%b, required 0/10", lock_abort, grant);
                end
            end
        join
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_drain: pending=%0d arb_busy=%b, required 0/0", exp_q.size(), arb_busy); end
    endtask

    task automatic test_no_busy();
        bit ok;
        int stamp [3];
        @(negedge clk);
        tx_mode = 1;
        for (int k = 0; k < 3; k++) exp_q.push_back(pack(0, 8'h90 + 8'(k)));
        fork
            send_bytes(0, 3, 8'h90, 3);
            begin
                for (int k = 0; k < 3; k++) begin
                    int t;
                    t = 0;
                    while (!new_tx_data && t < TMO) begin @(negedge clk); t++; end
                    stamp[k] = cyc;
                    @(negedge clk);
                end
            end
        join
        checks++; if (stamp[1] - stamp[0] != BUSY_WAIT + 2) begin
            errors++; $display("FAIL nobusy_gap1: got %0d cycles, required %0d", stamp[1] - stamp[0], BUSY_WAIT + 2);
        end
        checks++; if (stamp[2] - stamp[1] != BUSY_WAIT + 2) begin
            errors++; $display("FAIL nobusy_gap2: got %0d cycles, required %0d", stamp[2] - stamp[1], BUSY_WAIT + 2);
        end
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL nobusy_drain: pending=%0d arb_busy=%b, required 0/0", exp_q.size(), arb_busy); end
        tx_mode = 0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int t;
        @(negedge clk);
        rd[0] = 8'h5A; rl[0] = 1'b1; rv[0] = 1'b1;
        exp_q.push_back(pack(0, 8'h5A));
        t = 0; while (!new_tx_data && t < TMO) begin @(negedge clk); t++; end
        t = 0; while (!tx_busy && t < TMO) begin @(negedge clk); t++; end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (grant !== 2'b00 || req_ready !== 2'b00) begin
            errors++; $display("FAIL midrst_grant: got grant=%b ready=%b, required 00/00", grant, req_ready);
        end
        checks++; if (tx_data !== 8'h00 || new_tx_data !== 1'b0) begin
            errors++; $display("FAIL midrst_tx: got data=%h strobe=%b, required 00/0", tx_data, new_tx_data);
        end
        checks++; if (arb_busy !== 1'b0 || lock_abort !== 1'b0) begin
            errors++; $display("FAIL midrst_status: got arb_busy=%b abort=%b, required 0/0", arb_busy, lock_abort);
        end
        exp_q.push_back(pack(0, 8'h5A));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL midrst_regrant: got %b, required 01", grant); end
        t = 0; while (!req_ready[0] && t < TMO) begin @(negedge clk); t++; end
        rv[0] = 1'b0;
        wait_drain(ok);
        checks++; if (!ok) begin errors++; $display("FAIL midrst_drain: pending=%0d arb_busy=%b, required 0/0", exp_q.size(), arb_busy); end
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            rv[i] = 1'b0;
            rd[i] = 8'h00;
            rl[i] = 1'b0;
        end
        test_reset();
        test_single();
        test_simultaneous();
        test_alternate();
        test_packet_lock();
        test_stall_timeout();
        test_no_busy();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL final_queue: got %0d pending, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
